// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image, writes it
// word-by-word into the instruction ROM, then releases the core from reset.
module boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    WAIT, LEN_HI, LEN_LO, DATA, CSUM, HOLD, RUN, ERROR
  } state_t;

  localparam logic [31:0]     CAP = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [7:0]        len_hi;
  logic [ADDR_W:0]   len_words;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sh;
  logic [7:0]        csum;
  logic [31:0]       hold_cnt;
  logic [31:0]       len_full;
  logic              acc;
  logic              last_byte;
  logic              last_word;

  assign acc       = rx_valid & rx_ready;
  assign len_full  = {16'h0000, len_hi, rx_data};
  assign last_byte = (byte_cnt == 2'd3);
  assign last_word = ((word_cnt + ONE) == len_words);

  assign rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                    (state == DATA)   || (state == CSUM);
  assign cpu_rst  = (state != RUN);
  assign done     = (state == RUN);
  assign err      = (state == ERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:   state_nxt = LEN_HI;
      LEN_HI: if (acc) state_nxt = LEN_LO;
      LEN_LO: if (acc) begin
        if (len_full > CAP)        state_nxt = ERROR;
        else if (len_full == 32'd0) state_nxt = CSUM;
        else                        state_nxt = DATA;
      end
      DATA:   if (acc && last_byte && last_word) state_nxt = CSUM;
      CSUM:   if (acc) state_nxt = (rx_data == csum) ? HOLD : ERROR;
      HOLD:   if (hold_cnt == 32'(HOLD_CYCLES - 1)) state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  // Datapath: header capture, word assembly, ROM write strobe, checksum, hold timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi    <= 8'h00;
      len_words <= '0;
      word_cnt  <= '0;
      byte_cnt  <= 2'd0;
      word_sh   <= 24'h0;
      csum      <= 8'h00;
      hold_cnt  <= 32'd0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= 32'h0;
    end else begin
      rom_we <= 1'b0;
      if (state == LEN_HI && acc) len_hi <= rx_data;
      if (state == LEN_LO && acc) len_words <= len_full[ADDR_W:0];
      if (state == DATA && acc) begin
        byte_cnt <= byte_cnt + 2'd1;
        csum     <= csum ^ rx_data;
        word_sh  <= {word_sh[15:0], rx_data};
        if (last_byte) begin
          rom_we    <= 1'b1;
          rom_addr  <= word_cnt[ADDR_W-1:0];
          rom_wdata <= {word_sh, rx_data};
          word_cnt  <= word_cnt + ONE;
        end
      end
      if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed header/checksum cases plus
// randomized images with random rx_valid gaps checked against a byte-level model.
module tb_boot_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rom_we;
  logic [9:0]  rom_addr;
  logic [31:0] rom_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [31:0] img[$];
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  bit          exp_good;

  boot_loader #(.ADDR_W(10), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst && rom_we) got_q.push_back({rom_addr, rom_wdata});

  // Reference model: image words -> byte stream, expected writes, expected outcome
  task automatic build_stream(input bit bad);
    logic [15:0] len;
    logic [7:0]  cs, b;
    stream.delete();
    exp_q.delete();
    len = 16'(img.size());
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    cs = 8'h00;
    for (int k = 0; k < img.size(); k++) begin
      for (int j = 3; j >= 0; j--) begin
        b = img[k][8*j +: 8];
        stream.push_back(b);
        cs = cs ^ b;
      end
      exp_q.push_back({10'(k), img[k]});
    end
    if (bad) stream.push_back(cs ^ 8'($urandom_range(1, 255)));
    else     stream.push_back(cs);
    exp_good = !bad;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    repeat ($urandom_range(0, gap_max)) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_byte_timeout got rx_ready=%b exp 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap_max);
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], gap_max);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    got_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_end();
    int cyc = 0;
    while (!(done || err) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, err} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b",
               rx_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, err);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_ready got %b exp 0", rx_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_len_hi_ready got %b exp 1", rx_ready);
    end
  endtask

  task automatic test_basic(input bit bad);
    logic [7:0] s[11] = '{8'h00, 8'h02, 8'h34, 8'h02, 8'h00, 8'h01,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h37};
    do_reset();
    stream.delete();
    foreach (s[i]) stream.push_back(s[i]);
    if (bad) stream[10] = 8'h00;
    exp_q.delete();
    exp_q.push_back({10'd0, 32'h34020001});
    exp_q.push_back({10'd1, 32'h00000000});
    send_stream(1);
    if (!bad) begin
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL basic_hold_cpu_rst got %b exp 1", cpu_rst);
      end
      @(posedge clk); #1;
      checks++;
      if ({cpu_rst, done, err} !== 3'b010) begin
        errors++;
        $display("FAIL basic_run got crst/done/err=%b exp 010", {cpu_rst, done, err});
      end
    end else begin
      wait_end();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({err, cpu_rst, rx_ready, done} !== 4'b1100) begin
        errors++;
        $display("FAIL bad_csum_outputs got err/crst/rdy/done=%b exp 1100",
                 {err, cpu_rst, rx_ready, done});
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_write_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_write got %h exp %h", got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    stream.delete();
    stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    send_stream(2);
    checks++;
    if ({cpu_rst, done, err, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_len_hold got crst/done/err/rdy=%b exp 1000",
               {cpu_rst, done, err, rx_ready});
    end
    wait_end();
    checks++;
    if ({done, err, cpu_rst} !== 3'b100 || got_q.size() != 0) begin
      errors++;
      $display("FAIL zero_len_run got done/err/crst=%b writes=%0d exp 100 writes=0",
               {done, err, cpu_rst}, got_q.size());
    end
  endtask

  task automatic test_too_long();
    do_reset();
    stream.delete();
    stream.push_back(8'h04); stream.push_back(8'h01);
    send_stream(1);
    checks++;
    if ({err, rx_ready, cpu_rst} !== 3'b101) begin
      errors++;
      $display("FAIL too_long_error got err/rdy/crst=%b exp 101", {err, rx_ready, cpu_rst});
    end
    rx_valid = 1'b1;
    repeat (10) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    checks++;
    if ({err, done, rx_ready} !== 3'b100 || got_q.size() != 0) begin
      errors++;
      $display("FAIL too_long_sticky got err/done/rdy=%b writes=%0d exp 100 writes=0",
               {err, done, rx_ready}, got_q.size());
    end
  endtask

  task automatic test_random_images(input int n_img, input int len_min,
                                    input int len_max, input int gap_max,
                                    input bit allow_bad);
    bit bad;
    for (int t = 0; t < n_img; t++) begin
      do_reset();
      img.delete();
      repeat ($urandom_range(len_min, len_max)) img.push_back($urandom);
      bad = allow_bad ? 1'($urandom_range(0, 1)) : 1'b0;
      build_stream(bad);
      send_stream(gap_max);
      wait_end();
      checks++;
      if ({done, err} !== {exp_good, !exp_good}) begin
        errors++;
        $display("FAIL rand_outcome len=%0d got done/err=%b%b exp %b%b",
                 img.size(), done, err, exp_good, !exp_good);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_write_count got %0d exp %0d", got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_write idx=%0d got %h exp %h", i, got_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    img.delete();
    for (int k = 0; k < 3; k++) img.push_back($urandom | 32'h1);
    build_stream(1'b0);
    for (int i = 0; i < 7; i++) send_byte(stream[i], 1);
    checks++;
    if (got_q.size() != 1 || rom_addr !== 10'd0 || rom_wdata !== img[0]) begin
      errors++;
      $display("FAIL mid_partial got writes=%0d addr=%h wd=%h exp 1 0 %h",
               got_q.size(), rom_addr, rom_wdata, img[0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, err} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_outputs got rdy=%b we=%b addr=%h wd=%h crst=%b done=%b err=%b",
               rx_ready, rom_we, rom_addr, rom_wdata, cpu_rst, done, err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    test_random_images(1, 4, 6, 2, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_zero_len();
    test_too_long();
    test_random_images(6, 1, 8, 3, 1'b1);
    test_reset_mid();
    test_random_images(1, 1024, 1024, 2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-ROM word address width (capacity 2^ADDR_W words).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles the core stays in reset after a good checksum; legal range >=1.
REQ-003 SHALL have port clk  input  1  system clock, all state updated on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port rx_data  input  8  boot byte stream.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port rom_we  output  1  instruction-ROM write strobe, one cycle per word.
REQ-009 SHALL have port rom_addr  output  ADDR_W  ROM word address.
REQ-010 SHALL have port rom_wdata  output  32  ROM write data.
REQ-011 SHALL have port cpu_rst  output  1  reset to openmips_min_spoc, active-high (1 = core held in reset).
REQ-012 SHALL have port done  output  1  image loaded, core running.
REQ-013 SHALL have port err  output  1  load failed, core held in reset.

Function
REQ-014 SHALL accept a byte only on a rising edge where rx_valid=1 and rx_ready=1; gaps with rx_valid=0 of any length are legal and have no effect.
REQ-015 SHALL implement states WAIT, LEN_HI, LEN_LO, DATA, CSUM, HOLD, RUN, ERROR; rx_ready=1 only in LEN_HI, LEN_LO, DATA, CSUM.
REQ-016 SHALL go WAIT->LEN_HI unconditionally on the first edge after reset release.
REQ-017 SHALL take the word count LEN big-endian: LEN_HI byte = LEN[15:8], LEN_LO byte = LEN[7:0]; each state advances on acceptance.
REQ-018 SHALL, on LEN_LO acceptance: LEN > 2^ADDR_W -> ERROR; LEN = 0 -> CSUM; otherwise -> DATA.
REQ-019 SHALL assemble data words big-endian: the first byte of a word goes to bits 31:24, the fourth to bits 7:0.
REQ-020 SHALL, on the edge accepting the fourth byte of word k, register rom_we=1, rom_addr=k, rom_wdata=word; rom_we SHALL return to 0 on the next edge.
REQ-021 SHALL number words from address 0 with no wrap; the last word of a LEN=2^ADDR_W image is written at 2^ADDR_W-1.
REQ-022 SHALL go DATA->CSUM on the edge accepting the fourth byte of word LEN-1.
REQ-023 SHALL compute the checksum as the XOR of all data bytes (the length bytes are excluded); the initial value is 0x00.
REQ-024 SHALL, on CSUM acceptance, go to HOLD if the byte equals the computed checksum, else to ERROR.
REQ-025 SHALL stay in HOLD for exactly HOLD_CYCLES cycles and then enter RUN; RUN and ERROR are terminal until reset.
REQ-026 SHALL decode cpu_rst = 1 in every state except RUN, done = 1 only in RUN, and err = 1 only in ERROR.
REQ-027 SHALL keep all word-count arithmetic ADDR_W+1 bits wide and the byte-in-word counter 2 bits wide.

Reset
REQ-028 SHALL, while rst=0, force state=WAIT, rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_rst=1, done=0, err=0, checksum=0, and clear all counters.
REQ-029 SHALL, on reset asserted mid-operation in any state, abandon the partial image; the loader leaves ROM contents untouched and a new load requires a full new header.

Verification
REQ-030 SHALL pass: bytes 00 02 34 02 00 01 00 00 00 00 37 -> rom_we at addr 0 data 0x34020001, then at addr 1 data 0x00000000; cpu_rst falls 4 edges after the 0x37 acceptance; done=1, err=0.
REQ-031 SHALL pass: same stream with checksum byte 0x00 -> err=1, cpu_rst stays 1, rx_ready=0, done=0.
REQ-032 SHALL pass: bytes 00 00 00 -> no rom_we; state goes to HOLD and then RUN, done=1.
REQ-033 SHALL pass: bytes 04 01 -> ERROR after the second byte, rx_ready=0, further rx_valid ignored, no rom_we.
REQ-034 SHALL pass: a 0x0400-word image sent with random rx_valid gaps -> 1024 writes at addr 0..0x3FF in order, correct data, done=1.
REQ-035 SHALL pass: rst pulsed low after 5 data bytes -> all outputs at reset values immediately, then a fresh full image loads correctly.
